// File: rtl/fc_dense_if.sv
// Bus bundle for fc_dense: control handshake, L2/weight/bias read ports and the
// result-memory write port. The slave modport is the fc_dense side.
interface fc_dense_if #(
  parameter int DW   = 20,
  parameter int WA_W = 15
);
  logic            start;
  logic            busy;
  logic            done;
  logic            crd;
  logic [2:0]      csel;
  logic [11:0]     caddr_rd;
  logic [DW-1:0]   cdata_rd;
  logic [WA_W-1:0] waddr;
  logic [DW-1:0]   wdata;
  logic [3:0]      baddr;
  logic [DW-1:0]   bdata;
  logic            res_wr;
  logic [3:0]      res_addr;
  logic [DW-1:0]   res_data;

  modport slave (
    input  start, cdata_rd, wdata, bdata,
    output busy, done, crd, csel, caddr_rd, waddr, baddr,
           res_wr, res_addr, res_data
  );

  modport master (
    output start, cdata_rd, wdata, bdata,
    input  busy, done, crd, csel, caddr_rd, waddr, baddr,
           res_wr, res_addr, res_data
  );
endinterface

// File: rtl/fc_dense.sv
// Fully-connected output stage: N_OUT Q4.16 dot products over the flattened
// L2 feature vector, with bias, round-half-up, saturation and optional ReLU.
module fc_dense #(
  parameter int N_IN    = 2048,
  parameter int N_OUT   = 10,
  parameter int DW      = 20,
  parameter int FRAC    = 16,
  parameter int ACC_W   = 52,
  parameter int WA_W    = 15,
  parameter int RELU_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  fc_dense_if.slave   bus
);
  localparam int IW = $clog2(N_IN) + 1;
  localparam int RW = ACC_W - FRAC;
  localparam logic signed [RW-1:0] MAXV = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_ROUND, S_WRITE, S_DONE} state_t;

  state_t                   r_state;
  logic [IW-1:0]            r_i;
  logic [3:0]               r_o;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DW-1:0]            r_x_q, r_w_q, r_res_q;
  logic                     r_v_q;
  logic                     r_busy, r_done, r_crd, r_res_wr;
  logic [11:0]              r_caddr;
  logic [WA_W-1:0]          r_waddr;
  logic [3:0]               r_res_addr;

  logic signed [2*DW-1:0]   w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext, w_bias_ext, w_s;
  logic signed [RW-1:0]     w_r;
  logic [DW-1:0]            w_res;

  assign w_prod     = $signed(r_x_q) * $signed(r_w_q);
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-DW){bus.bdata[DW-1]}}, bus.bdata};
  assign w_s        = r_acc + (w_bias_ext <<< FRAC);
  // Dropping the fraction floors; adding the first discarded bit rounds half up.
  assign w_r        = w_s[ACC_W-1:FRAC] + {{(RW-1){1'b0}}, w_s[FRAC-1]};

  always_comb begin
    w_res = w_r[DW-1:0];
    if (w_r > MAXV)      w_res = {1'b0, {(DW-1){1'b1}}};
    else if (w_r < MINV) w_res = {1'b1, {(DW-1){1'b0}}};
    if (RELU_EN != 0 && w_res[DW-1]) w_res = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_o        <= '0;
      r_acc      <= '0;
      r_x_q      <= '0;
      r_w_q      <= '0;
      r_v_q      <= 1'b0;
      r_res_q    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_res_wr   <= 1'b0;
      r_caddr    <= '0;
      r_waddr    <= '0;
      r_res_addr <= '0;
    end else begin
      r_v_q    <= 1'b0;
      r_crd    <= 1'b0;
      r_res_wr <= 1'b0;
      r_done   <= 1'b0;
      if (r_v_q) r_acc <= r_acc + w_prod_ext;
      // Read strobes/addresses are set one cycle early so they are valid in LOAD.
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= S_LOAD;
          r_busy  <= 1'b1;
          r_crd   <= 1'b1;
          r_caddr <= '0;
          r_waddr <= '0;
        end
        S_LOAD: begin
          r_x_q <= bus.cdata_rd;
          r_w_q <= bus.wdata;
          r_v_q <= 1'b1;
          if (r_i == IW'(N_IN-1)) begin
            r_state <= S_DRAIN;
            r_i     <= '0;
          end else begin
            r_i     <= r_i + 1'b1;
            r_crd   <= 1'b1;
            r_caddr <= r_caddr + 12'd1;
            r_waddr <= r_waddr + 1'b1;
          end
        end
        S_DRAIN: r_state <= S_ROUND;
        S_ROUND: begin
          r_res_q    <= w_res;
          r_res_addr <= r_o;
          r_res_wr   <= 1'b1;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          r_acc <= '0;
          r_o   <= r_o + 4'd1;
          if (r_o == 4'(N_OUT-1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            // Next neuron's weights follow contiguously: o*N_IN+N_IN-1 +1.
            r_state <= S_LOAD;
            r_crd   <= 1'b1;
            r_caddr <= '0;
            r_waddr <= r_waddr + 1'b1;
          end
        end
        S_DONE: begin
          r_o     <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.crd      = r_crd;
  assign bus.csel     = r_crd ? 3'b101 : 3'b000;
  assign bus.caddr_rd = r_caddr;
  assign bus.waddr    = r_waddr;
  assign bus.baddr    = r_o;
  assign bus.res_wr   = r_res_wr;
  assign bus.res_addr = r_res_addr;
  assign bus.res_data = r_res_q;
endmodule
